// File: rtl/byte_striping_pkg.sv
// ---------------------------------------------------------------------------
// byte_striping_pkg
//   Shared definitions for the byte-striping controller slice.
//   - NUM_LANES / DATA_W : lane count and byte width of the striped group
//   - PAD_BYTE           : filler byte for unused or padded lanes
//   - MODE_1L/2L/4L      : laneMode encodings (3 also means 4 lanes)
//   - stageState_t       : staging FSM states
//   - mode_to_n()        : laneMode -> number of active lanes
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package byte_striping_pkg;

  localparam int NUM_LANES = 4;
  localparam int DATA_W    = 8;

  localparam logic [7:0] PAD_BYTE = 8'hF7;

  localparam logic [1:0] MODE_1L = 2'd0;
  localparam logic [1:0] MODE_2L = 2'd1;
  localparam logic [1:0] MODE_4L = 2'd2;

  // FILL: staging is collecting bytes; FULL: staging holds a finished group
  // that is waiting for the output register to drain.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } stageState_t;

  // Encoding 3 is treated like MODE_4L so every laneMode value is legal.
  function automatic logic [2:0] mode_to_n(input logic [1:0] mode);
    case (mode)
      MODE_1L: return 3'd1;
      MODE_2L: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/byte_striping_ctrl_if.sv
// ---------------------------------------------------------------------------
// byte_striping_ctrl_if
//   Bundles the byte-stream side and the lane side of the striping controller.
//   Byte side : byteStripingIN, laneVLD, byteStripingRDY, laneMode, flush
//   Lane side : stripedLane0..3, byteStripingVLD, laneRDY,
//               laneParity (only when BYTE_STRIPING_PARITY_EN is defined)
//   Modports  : master = environment driving bytes and consuming groups,
//               slave  = the controller itself.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface byte_striping_ctrl_if #(parameter int DATA_W = 8);

  logic [DATA_W-1:0] byteStripingIN;
  logic              laneVLD;
  logic              byteStripingRDY;
  logic [1:0]        laneMode;
  logic              flush;

  logic [DATA_W-1:0] stripedLane0;
  logic [DATA_W-1:0] stripedLane1;
  logic [DATA_W-1:0] stripedLane2;
  logic [DATA_W-1:0] stripedLane3;
  logic              byteStripingVLD;
  logic              laneRDY;

`ifdef BYTE_STRIPING_PARITY_EN
  logic [3:0]        laneParity;

  modport master (
    output byteStripingIN, laneVLD, laneMode, flush, laneRDY,
    input  byteStripingRDY, stripedLane0, stripedLane1, stripedLane2,
           stripedLane3, byteStripingVLD, laneParity
  );

  modport slave (
    input  byteStripingIN, laneVLD, laneMode, flush, laneRDY,
    output byteStripingRDY, stripedLane0, stripedLane1, stripedLane2,
           stripedLane3, byteStripingVLD, laneParity
  );
`else
  modport master (
    output byteStripingIN, laneVLD, laneMode, flush, laneRDY,
    input  byteStripingRDY, stripedLane0, stripedLane1, stripedLane2,
           stripedLane3, byteStripingVLD
  );

  modport slave (
    input  byteStripingIN, laneVLD, laneMode, flush, laneRDY,
    output byteStripingRDY, stripedLane0, stripedLane1, stripedLane2,
           stripedLane3, byteStripingVLD
  );
`endif

endinterface

// File: rtl/byte_striping_lane_cnt.sv
// ---------------------------------------------------------------------------
// byte_striping_lane_cnt
//   Tracks where the next byte goes within the group being gathered and
//   decides when that group is complete.
//   Ports:
//     clk1Mhz, reset : clock, synchronous active-high reset
//     accept         : a byte is taken this cycle
//     flush          : request to close the current partial group
//     stageFill      : staging FSM is in FILL
//     laneMode       : requested lane mode (sampled only at group start)
//     idx            : staging slot for the next byte
//     fillCount      : bytes in the group including this cycle's byte
//     groupDone      : group closes on this edge (full or flushed)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module byte_striping_lane_cnt
  import byte_striping_pkg::*;
(
  input  logic       clk1Mhz,
  input  logic       reset,
  input  logic       accept,
  input  logic       flush,
  input  logic       stageFill,
  input  logic [1:0] laneMode,
  output logic [1:0] idx,
  output logic [2:0] fillCount,
  output logic       groupDone
);

  logic [2:0] laneCntReg;
  logic [2:0] laneCntEff;
  logic       groupStart;

  // At the start of a group the live laneMode decides N, so a one-lane
  // group can already complete on its first byte. Mid-group the frozen
  // copy is used, which is how a mode change is deferred to the next group.
  always_comb begin
    groupStart = (idx == 2'd0) && stageFill;
    laneCntEff = groupStart ? mode_to_n(laneMode) : laneCntReg;
    fillCount  = {1'b0, idx} + {2'b00, accept};
    groupDone  = stageFill && (fillCount != 3'd0) &&
                 ((fillCount == laneCntEff) || flush);
  end

  always_ff @(posedge clk1Mhz) begin
    if (reset) begin
      idx        <= 2'd0;
      laneCntReg <= 3'd4;
    end else begin
      if (groupStart) begin
        laneCntReg <= mode_to_n(laneMode);
      end
      if (groupDone) begin
        idx <= 2'd0;
      end else if (accept) begin
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/byte_striping_ctrl.sv
// ---------------------------------------------------------------------------
// byte_striping_ctrl
//   Gathers a serial byte stream into groups of 1, 2 or 4 bytes (one per
//   lane) and presents each group on stripedLane0..3 with a valid/ready
//   handshake. A staging buffer behind the output register lets a
//   full-rate stream continue without stalls while the lane side is ready.
//   Ports:
//     clk1Mhz : byte-rate clock, rising edge
//     reset   : synchronous active-high reset
//     bus     : byte_striping_ctrl_if.slave (byte side and lane side)
//   Parameters:
//     DATA_W   : byte width per lane
//     PAD_BYTE : byte placed on unused or padded lanes
//   Build option:
//     BYTE_STRIPING_PARITY_EN : adds laneParity, the even parity of each
//                               output lane, registered with the lanes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module byte_striping_ctrl
  import byte_striping_pkg::*;
#(
  parameter int                DATA_W   = byte_striping_pkg::DATA_W,
  parameter logic [DATA_W-1:0] PAD_BYTE = byte_striping_pkg::PAD_BYTE
) (
  input logic                 clk1Mhz,
  input logic                 reset,
  byte_striping_ctrl_if.slave bus
);

  stageState_t       stageState;
  logic [DATA_W-1:0] staging   [NUM_LANES];
  logic [DATA_W-1:0] outLane   [NUM_LANES];
  logic [DATA_W-1:0] groupNext [NUM_LANES];
  logic              outVld;

  logic       accept;
  logic       stageFill;
  logic       drain;
  logic       toStage;
  logic       toOut;
  logic [1:0] idx;
  logic [2:0] fillCount;
  logic       groupDone;

  byte_striping_lane_cnt u_laneCnt (
    .clk1Mhz   (clk1Mhz),
    .reset     (reset),
    .accept    (accept),
    .flush     (bus.flush),
    .stageFill (stageFill),
    .laneMode  (bus.laneMode),
    .idx       (idx),
    .fillCount (fillCount),
    .groupDone (groupDone)
  );

  // A finished group goes to staging only when the output register is busy
  // and is not emptying on this edge; otherwise it bypasses straight to the
  // output so the normal latency is a single cycle.
  always_comb begin
    stageFill = (stageState == FILL);
    accept    = bus.laneVLD && stageFill && !reset;
    drain     = outVld && bus.laneRDY;
    toStage   = groupDone && outVld && !bus.laneRDY;
    toOut     = groupDone && !toStage;
  end

  // The closing group: slots already filled, this cycle's byte at idx, and
  // PAD_BYTE everywhere past the fill point. Because a normal group holds
  // exactly N bytes, the same rule pads both short modes and flushes.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      groupNext[k] = PAD_BYTE;
      if (3'(k) < fillCount) begin
        groupNext[k] = (2'(k) == idx) ? bus.byteStripingIN : staging[k];
      end
    end
  end

`ifdef BYTE_STRIPING_PARITY_EN
  logic [3:0] parityReg;
  logic [3:0] groupNextPar;
  logic [3:0] stagingPar;

  // Parity is computed on whatever is about to be loaded so it always
  // matches the lanes it is registered alongside, pad lanes included.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      groupNextPar[k] = ^groupNext[k];
      stagingPar[k]   = ^staging[k];
    end
  end

  assign bus.laneParity = parityReg;
`endif

  // Staging FSM plus the output register. In FILL bytes land in staging and
  // finished groups go either to the output or into staging (-> FULL). In
  // FULL the input is stalled until the output drains, at which point the
  // staged group takes its place on the same edge and VLD stays high.
  always_ff @(posedge clk1Mhz) begin
    if (reset) begin
      stageState <= FILL;
      outVld     <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        staging[k] <= '0;
        outLane[k] <= '0;
      end
`ifdef BYTE_STRIPING_PARITY_EN
      parityReg <= 4'b0000;
`endif
    end else begin
      case (stageState)
        FILL: begin
          if (toStage) begin
            for (int k = 0; k < NUM_LANES; k++) begin
              staging[k] <= groupNext[k];
            end
            stageState <= FULL;
          end else if (accept) begin
            staging[idx] <= bus.byteStripingIN;
          end
          if (toOut) begin
            for (int k = 0; k < NUM_LANES; k++) begin
              outLane[k] <= groupNext[k];
            end
            outVld <= 1'b1;
`ifdef BYTE_STRIPING_PARITY_EN
            parityReg <= groupNextPar;
`endif
          end else if (drain) begin
            outVld <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            for (int k = 0; k < NUM_LANES; k++) begin
              outLane[k] <= staging[k];
            end
            outVld     <= 1'b1;
            stageState <= FILL;
`ifdef BYTE_STRIPING_PARITY_EN
            parityReg <= stagingPar;
`endif
          end
        end
        default: stageState <= FILL;
      endcase
    end
  end

  assign bus.byteStripingRDY = stageFill && !reset;
  assign bus.byteStripingVLD = outVld;
  assign bus.stripedLane0    = outLane[0];
  assign bus.stripedLane1    = outLane[1];
  assign bus.stripedLane2    = outLane[2];
  assign bus.stripedLane3    = outLane[3];

endmodule
